// File: rtl/hash_seq_if.sv
// hash_seq_if: command, byte-stream handshake and round-strobe bundle for hash_seq_ctrl.
// master is the controller side, slave is the message source / hash datapath side.
interface hash_seq_if #(
    parameter int LEN_W = 64
);
    logic             start;
    logic [LEN_W-1:0] len_in;
    logic             m_valid;
    logic             m_ready;
    logic             h_init;
    logic             rnd_en;
    logic             rnd_src;
    logic [2:0]       len_sel;
    logic [7:0]       len_byte;
    logic             busy;
    logic             hash_ready;
    logic             hash_ack;
    logic             err;

    modport master (
        input  start, len_in, m_valid, hash_ack,
        output m_ready, h_init, rnd_en, rnd_src, len_sel, len_byte, busy, hash_ready, err
    );

    modport slave (
        output start, len_in, m_valid, hash_ack,
        input  m_ready, h_init, rnd_en, rnd_src, len_sel, len_byte, busy, hash_ready, err
    );
endinterface

// File: rtl/hash_seq_ctrl.sv
// hash_seq_ctrl: sequences IV load, per-byte rounds and length-fold rounds of the hash datapath.
// Define HASH_SEQ_ZERO_LEN_EN to accept zero-length messages instead of flagging err.
module hash_seq_ctrl #(
    parameter int LEN_W        = 64,
    parameter int FINAL_ROUNDS = 8
) (
    input logic        clk,
    input logic        rst_n,
    hash_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, MSG, FIN, DONE} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic [2:0]       f_q, f_d;
    logic             err_d;
    logic             m_ready_q, h_init_q, fin_q, busy_q, hash_ready_q, err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = 1'b0;
        f_d     = (state_q == FIN) ? f_q + 3'd1 : 3'd0;
        case (state_q)
            IDLE: if (bus.start) begin
                if (bus.len_in != '0) begin
                    state_d = LOAD;
                    cnt_d   = bus.len_in;
                    len_d   = bus.len_in;
                end else begin
`ifdef HASH_SEQ_ZERO_LEN_EN
                    state_d = LOAD;
                    cnt_d   = '0;
                    len_d   = '0;
`else
                    err_d   = 1'b1;
`endif
                end
            end
            LOAD: state_d = (cnt_q == '0) ? FIN : MSG;
            MSG: if (bus.m_valid) begin
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) state_d = FIN;
            end
            FIN:  if (f_q == 3'(FINAL_ROUNDS - 1)) state_d = DONE;
            DONE: if (bus.hash_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered as a decode of the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            f_q          <= 3'd0;
            m_ready_q    <= 1'b0;
            h_init_q     <= 1'b0;
            fin_q        <= 1'b0;
            busy_q       <= 1'b0;
            hash_ready_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            f_q          <= f_d;
            m_ready_q    <= state_d == MSG;
            h_init_q     <= state_d == LOAD;
            fin_q        <= state_d == FIN;
            busy_q       <= state_d != IDLE;
            hash_ready_q <= state_d == DONE;
            err_q        <= err_d;
        end
    end

    assign bus.m_ready    = m_ready_q;
    assign bus.h_init     = h_init_q;
    assign bus.rnd_en     = (m_ready_q & bus.m_valid) | fin_q;
    assign bus.rnd_src    = fin_q;
    assign bus.len_sel    = fin_q ? f_q : 3'd0;
    assign bus.len_byte   = 8'(len_q >> {bus.len_sel, 3'b000});
    assign bus.busy       = busy_q;
    assign bus.hash_ready = hash_ready_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_hash_seq_ctrl.sv
// tb_hash_seq_ctrl: scoreboard bench; the driver pushes the per-cycle expected outputs
// derived from the command timing and a negedge monitor pops and compares them.
module tb_hash_seq_ctrl;
    typedef struct {
        string       tag;
        logic [17:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] cap_len = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    exp_t        e_m;

    hash_seq_if #(.LEN_W(64)) bus ();

    hash_seq_ctrl #(.LEN_W(64), .FINAL_ROUNDS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] obs();
        return {bus.m_ready, bus.h_init, bus.rnd_en, bus.rnd_src, bus.len_sel,
                bus.busy, bus.hash_ready, bus.err, bus.len_byte};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (mr,hi,re,rs,ls,bz,hr,er,lb)", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e_m = sb.pop_front();
            chk(e_m.tag, 32'(obs()), 32'(e_m.v));
        end
    end

    // Push the expectation for the current cycle, then advance to 1ns after the next edge.
    task automatic cyc(input string tag, input bit mr, input bit hi, input bit re, input bit rs,
                       input logic [2:0] ls, input bit bz, input bit hr, input bit er);
        exp_t e;
        e.tag = tag;
        e.v   = {mr, hi, re, rs, ls, bz, hr, er, 8'(cap_len >> {ls, 3'b000})};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        cyc("idle", 0, 0, 0, 0, 3'd0, 0, 0, 0);
    endtask

    // stall bit k drops m_valid in the k-th MSG cycle; spam pulses start while busy.
    task automatic run(input logic [63:0] n, input logic [31:0] stall, input int hold, input bit spam);
        int acc = 0;
        int k = 0;
        bus.start  = 1'b1;
        bus.len_in = n;
        idle_cyc();
        cap_len      = n;
        bus.start    = spam;
        bus.len_in   = 64'd9;
        bus.m_valid  = 1'b1;
        bus.hash_ack = 1'b1;
        cyc("load", 0, 1, 0, 0, 3'd0, 1, 0, 0);
        bus.hash_ack = 1'b0;
        while (acc < int'(n)) begin
            bus.m_valid = !stall[k];
            cyc("msg", 1, 0, bus.m_valid, 0, 3'd0, 1, 0, 0);
            acc += int'(bus.m_valid);
            k++;
        end
        bus.m_valid = 1'b1;
        for (int f = 0; f < 8; f++) cyc("fin", 0, 0, 1, 1, 3'(f), 1, 0, 0);
        bus.m_valid = 1'b0;
        for (int h = 0; h < hold; h++) cyc("done_hold", 0, 0, 0, 0, 3'd0, 1, 1, 0);
        bus.hash_ack = 1'b1;
        cyc("done_ack", 0, 0, 0, 0, 3'd0, 1, 1, 0);
        bus.hash_ack = 1'b0;
        bus.start    = 1'b0;
        idle_cyc();
        idle_cyc();
    endtask

    // Runs into MSG/FIN for a while, then pulls reset asynchronously mid-cycle.
    task automatic partial(input logic [63:0] n, input int msg_cycles, input int fin_cycles);
        bus.start  = 1'b1;
        bus.len_in = n;
        idle_cyc();
        cap_len     = n;
        bus.start   = 1'b0;
        bus.m_valid = 1'b1;
        cyc("load", 0, 1, 0, 0, 3'd0, 1, 0, 0);
        for (int m = 0; m < msg_cycles; m++) cyc("msg", 1, 0, 1, 0, 3'd0, 1, 0, 0);
        for (int f = 0; f < fin_cycles; f++) cyc("fin", 0, 0, 1, 1, 3'(f), 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'(obs()), 32'd0);
        cap_len = '0;
        bus.m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.start    = 1'b0;
        bus.len_in   = '0;
        bus.m_valid  = 1'b0;
        bus.hash_ack = 1'b0;
        #12;
        chk("reset", 32'(obs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_cyc();
        run(64'd3, 32'd0, 0, 1'b0);
        run(64'd2, 32'b0101, 0, 1'b0);
        run(64'd5, 32'd0, 20, 1'b1);
        bus.start  = 1'b1;
        bus.len_in = '0;
        idle_cyc();
        bus.start = 1'b0;
`ifdef HASH_SEQ_ZERO_LEN_EN
        cap_len = '0;
        cyc("z_load", 0, 1, 0, 0, 3'd0, 1, 0, 0);
        for (int f = 0; f < 8; f++) cyc("z_fin", 0, 0, 1, 1, 3'(f), 1, 0, 0);
        bus.hash_ack = 1'b1;
        cyc("z_done", 0, 0, 0, 0, 3'd0, 1, 1, 0);
        bus.hash_ack = 1'b0;
`else
        cyc("z_err", 0, 0, 0, 0, 3'd0, 0, 0, 1);
        idle_cyc();
`endif
        idle_cyc();
        partial(64'd4, 4, 2);
        run(64'd1, 32'd0, 0, 1'b0);
        partial(64'hFFFF_FFFF_FFFF_FFFF, 6, 0);
        run(64'd7, 32'b1010_0110, 2, 1'b0);
        @(negedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/hash_seq_ctrl.md
# hash_seq_ctrl

Sequencing controller for the byte-serial DES-S-box hash round datapath. It accepts a message-length command and runs the valid/ready handshake on the incoming byte stream. It issues one round-enable per accepted byte, then eight final rounds fed from the little-endian length bytes, and holds a digest-ready flag until acknowledged. It sits between the message source and the hash state register/round logic, which it drives through load, enable and mux-select strobes.

## Interface
- LEN_W, 64, width of message length and internal byte counter (must be ≥ 8)
- FINAL_ROUNDS, 8, number of length-fold rounds after the last message byte (1..8)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- len_in  in  LEN_W  message length in bytes, captured with start
- m_valid  in  1  message byte valid
- m_ready  out  1  controller accepts byte this cycle
- h_init  out  1  load hash state with IV constants
- rnd_en  out  1  hash state captures round output this cycle
- rnd_src  out  1  0 = round index from message byte, 1 = from length byte
- len_sel  out  3  selects byte len_sel of captured length (byte 0 = LSB) when rnd_src=1
- busy  out  1  high in every state except IDLE
- hash_ready  out  1  digest valid; held until hash_ack
- hash_ack  in  1  consumer has taken digest
- err  out  1  one-cycle pulse on rejected command

## Operation
- States: IDLE, LOAD, MSG, FIN, DONE; encoded in a 3-bit register.
- IDLE: m_ready=0, rnd_en=0. On start with len_in≠0, capture len_in into len_q and byte counter cnt, go to LOAD.
- LOAD (exactly one cycle): h_init=1, all other strobes 0. Next state MSG.
- MSG: m_ready=1, rnd_src=0.
  - rnd_en = m_valid (combinational; handshake and round in the same cycle).
  - On each accepted byte, cnt decrements.
  - Accept with cnt==1 → FIN, fin counter f=0.
  - m_valid low → stall, with no state change.
- FIN: rnd_en=1 every cycle, rnd_src=1, len_sel=f, m_ready=0. f increments; after f==FINAL_ROUNDS-1 → DONE.
- DONE: hash_ready=1, no strobes. hash_ack → IDLE in the next cycle, and hash_ready drops in that cycle. hash_ack outside DONE is ignored.
- start outside IDLE is ignored, with no err. start and hash_ack in the same DONE cycle: the ack is honoured and the start is dropped.
- cnt arithmetic is unsigned LEN_W-bit and never wraps; len_in = 2^LEN_W−1 is legal.
- Reset mid-operation (any state) → IDLE, with the partial hash abandoned. The IV is reloaded only via LOAD on the next command.

## Timing
- Reset values:
  - m_ready=0, h_init=0, rnd_en=0, rnd_src=0, len_sel=0.
  - busy=0, hash_ready=0, err=0.
  - state=IDLE, cnt=0, len_q=0.
- All outputs are decoded from registered state/counters, except rnd_en in MSG (= m_valid).
- For length N with m_valid held high, start sampled at edge 0:
  - LOAD in cycle 1.
  - MSG in cycles 2..N+1.
  - FIN in cycles N+2..N+1+FINAL_ROUNDS.
  - hash_ready from cycle N+2+FINAL_ROUNDS.
- Each m_valid low cycle in MSG adds exactly one cycle of latency.
- len_sel is 0 outside FIN.

## Configuration
- HASH_SEQ_ZERO_LEN_EN defined:
  - start with len_in==0 is accepted: IDLE → LOAD → FIN, skipping MSG entirely.
  - hash_ready appears at cycle 2+FINAL_ROUNDS.
- Undefined:
  - start with len_in==0 stays in IDLE.
  - err pulses for one cycle, in the cycle after the sampling edge.
  - No other output changes.

## Test plan
- Reset mid-FIN (N=4, assert rst_n low in FIN cycle 3) → all outputs 0 immediately (asynchronous), IDLE after release. A subsequent start with N=1 completes normally, with hash_ready at cycle 11.
- N=3, m_valid constant 1, FINAL_ROUNDS=8:
  - h_init high in cycle 1 only.
  - rnd_en in cycles 2–12.
  - len_sel 0..7 in cycles 5–12.
  - hash_ready rises at cycle 13.
- N=2 with m_valid low in MSG cycles 2 and 4 → exactly 2 accepted bytes, and hash_ready rises at cycle 14. rnd_en is never high while m_valid is low.
- Hold hash_ack=0 for 20 cycles in DONE, and pulse start repeatedly → hash_ready stays 1 with no err and no state change. hash_ack=1 → IDLE next cycle.
- len_in=0:
  - With HASH_SEQ_ZERO_LEN_EN: FIN cycles 2–9, then hash_ready at cycle 10.
  - Without it: err pulses once in cycle 1 and busy stays 0.
